// File: rtl/ucsbece154a_mem_arbiter.sv
// Purpose : shares one single-port memory between the fetch (I) and load/store (D) ports.
// Latency : request sampled in IDLE at cycle k -> MEM_LAT ACCESS cycles -> ready pulse at k+MEM_LAT+1.
// Backpr. : requesters hold req until their ready pulse; requests are ignored outside IDLE.
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   i_req/i_addr               - fetch request in; i_ready/i_rdata out
//   d_req/d_we/d_addr/d_wdata  - load/store request in; d_ready/d_rdata out
//   mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in - memory side
//   busy                       - arbiter not idle; grant_d - current/last owner (1 = D)
//
// Build option: define ARB_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise D always beats I.
module ucsbece154a_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;  // 1 = D owns the current/last access
  logic              win_d;             // D wins the arbitration this cycle

  // Arbitration. The owner register doubles as the last-grant memory for
  // round-robin: it resets to I, so D takes the first contest.
`ifdef ARB_RR_EN
  assign win_d = d_req && (!i_req || !owner_q);
`else
  assign win_d = d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    owner_d = owner_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    i_ready = 1'b0;
    d_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = win_d;
          addr_d  = win_d ? d_addr : i_addr;
          we_d    = win_d && d_we;
          if (win_d) wdata_d = d_wdata;
          count_d = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        // Strobe only on the last access cycle so each store writes exactly once.
        mem_we = we_q && (count_q == '0);
        if (count_q == '0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      RESP: begin
        i_ready = !owner_q;
        d_ready = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign busy      = (state_q != IDLE);
  assign grant_d   = owner_q;

endmodule
